// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Sequences one convolution layer. It streams a full weight set into the
//   layer RAM, then runs frames: it pulses the layer start and counts output
//   handshakes until one frame of N_OUT rows has been produced.
//
// Ports
//   clk_i, reset_i      clock; asynchronous active-high reset
//   load_i              request a weight reload (IDLE / LOADED)
//   run_i               request one frame (LOADED only)
//   cfg_valid_i/ready_o weight stream handshake, ready only while loading
//   cfg_data_i          weight / bias word
//   mem_addr_o          RAM address {conv_index+1, kernel_addr}
//   wen_o, mem_data_o   registered RAM write strobe and data
//   layer_start_o       one-cycle layer start pulse
//   layer_valid_i/ready_i  observed layer output handshake
//   loaded_o            a complete weight set is present
//   busy_o              loading, starting or running
//   frame_done_o        one-cycle end-of-frame pulse
//   frame_count_o       completed frames (wraps)
module conv_layer_sequencer #(
  parameter int KERNEL_HEIGHT      = 5,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16,
  parameter int N_CONVOLUTIONS     = 256,
  parameter int INPUT_LAYER_HEIGHT = 64,
  localparam int K  = KERNEL_HEIGHT * KERNEL_WIDTH,
  localparam int CW = $clog2(N_CONVOLUTIONS + 1),
  localparam int KW = $clog2(K + 1),
  localparam int AW = CW + KW
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [WORD_SIZE-1:0] cfg_data_i,
  output logic [AW-1:0]        mem_addr_o,
  output logic                 wen_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 layer_start_o,
  input  logic                 layer_valid_i,
  input  logic                 layer_ready_i,
  output logic                 loaded_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_count_o
);

  localparam int N_OUT = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
  localparam int OW    = $clog2(N_OUT + 1);

  localparam logic [CW-1:0] LAST_CONV  = CW'(N_CONVOLUTIONS - 1);
  localparam logic [KW-1:0] LAST_KADDR = KW'(K);
  localparam logic [OW-1:0] LAST_OUT   = OW'(N_OUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    START,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   conv_index;
  logic [KW-1:0]   kernel_addr;
  logic [OW-1:0]   out_count;
  logic            out_hs;

  assign out_hs      = layer_valid_i && layer_ready_i;

  // Both are plain decodes of the registered state, so they are glitch-free
  // and read 0 while reset holds the state in IDLE.
  assign cfg_ready_o = (state == LOAD);
  assign busy_o      = (state == LOAD) || (state == START) || (state == RUN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      conv_index    <= '0;
      kernel_addr   <= '0;
      out_count     <= '0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      wen_o         <= 1'b0;
      layer_start_o <= 1'b0;
      loaded_o      <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_count_o <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      wen_o         <= 1'b0;
      layer_start_o <= 1'b0;
      frame_done_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (load_i) begin
            state       <= LOAD;
            conv_index  <= '0;
            kernel_addr <= '0;
            loaded_o    <= 1'b0;
          end
        end

        LOAD: begin
          if (cfg_valid_i) begin
            // Kernel slot 0 of the RAM is reserved, hence conv_index+1.
            wen_o      <= 1'b1;
            mem_addr_o <= {conv_index + CW'(1), kernel_addr};
            mem_data_o <= cfg_data_i;
            if (kernel_addr == LAST_KADDR) begin
              kernel_addr <= '0;
              if (conv_index == LAST_CONV) begin
                conv_index <= '0;
                state      <= LOADED;
                loaded_o   <= 1'b1;
              end else begin
                conv_index <= conv_index + 1'b1;
              end
            end else begin
              kernel_addr <= kernel_addr + 1'b1;
            end
          end
        end

        LOADED: begin
          if (load_i) begin
            state       <= LOAD;
            conv_index  <= '0;
            kernel_addr <= '0;
            loaded_o    <= 1'b0;
          end else if (run_i) begin
            state         <= START;
            layer_start_o <= 1'b1;
            out_count     <= '0;
          end
        end

        START: begin
          state <= RUN;
        end

        RUN: begin
          if (out_hs) begin
            if (out_count == LAST_OUT) begin
              out_count     <= '0;
              state         <= LOADED;
              frame_done_o  <= 1'b1;
              frame_count_o <= frame_count_o + 16'd1;
            end else begin
              out_count <= out_count + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer with a small geometry
// (K=4, 3 kernels, N_OUT=5). Stimulus pushes expected RAM writes, layer
// starts and frame completions into queues; a monitor process pops and
// compares whenever the DUT presents one of those events.
module tb_conv_layer_sequencer;

  localparam int AW = 5;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        load_i = 1'b0;
  logic        run_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [15:0] cfg_data_i = '0;
  logic [AW-1:0] mem_addr_o;
  logic        wen_o;
  logic [15:0] mem_data_o;
  logic        layer_start_o;
  logic        layer_valid_i = 1'b0;
  logic        layer_ready_i = 1'b0;
  logic        loaded_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] frame_count_o;

  conv_layer_sequencer #(
    .KERNEL_HEIGHT(2),
    .KERNEL_WIDTH(2),
    .WORD_SIZE(16),
    .N_CONVOLUTIONS(3),
    .INPUT_LAYER_HEIGHT(6)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .load_i(load_i),
    .run_i(run_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_data_i(cfg_data_i),
    .mem_addr_o(mem_addr_o),
    .wen_o(wen_o),
    .mem_data_o(mem_data_o),
    .layer_start_o(layer_start_o),
    .layer_valid_i(layer_valid_i),
    .layer_ready_i(layer_ready_i),
    .loaded_o(loaded_o),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Hand-derived RAM addresses {conv+1, kaddr} for the 15 words.
  localparam logic [AW-1:0] EXP_ADDR [15] = '{
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd16, 5'd17, 5'd18, 5'd19, 5'd20,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28
  };

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] fq[$];
  int          pending_starts = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake sampled at the edge, outputs checked 1 time unit later.
  always begin
    logic  hs;
    wr_t   w;
    logic [15:0] fc;
    @(posedge clk_i);
    hs = cfg_valid_i && cfg_ready_o;
    #1;
    if (!reset_i) begin
      if (hs || wen_o) begin
        check("wen_after_handshake", {31'd0, wen_o}, {31'd0, hs});
        if (wen_o) begin
          if (wq.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            w = wq.pop_front();
            check("write_addr", {27'd0, mem_addr_o}, {27'd0, w.addr});
            check("write_data", {16'd0, mem_data_o}, {16'd0, w.data});
          end
        end
      end
      if (layer_start_o) begin
        if (pending_starts == 0) check("unexpected_layer_start", 32'd1, 32'd0);
        else pending_starts--;
      end
      if (frame_done_o) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          fc = fq.pop_front();
          check("frame_count", {16'd0, frame_count_o}, {16'd0, fc});
          check("busy_at_done", {31'd0, busy_o}, 32'd0);
        end
      end
    end
  end

  task automatic do_load(input bit throttle, input bit with_run);
    int unsigned n;
    bit          tog;
    n   = 0;
    tog = 1'b0;
    @(negedge clk_i);
    load_i = 1'b1;
    run_i  = with_run;
    @(negedge clk_i);
    load_i = 1'b0;
    run_i  = 1'b0;
    check("load_ready", {31'd0, cfg_ready_o}, 32'd1);
    check("load_loaded_clear", {31'd0, loaded_o}, 32'd0);
    check("load_busy", {31'd0, busy_o}, 32'd1);
    if (with_run) check("load_no_start", {31'd0, layer_start_o}, 32'd0);
    while (n < 15) begin
      if (throttle && tog) begin
        cfg_valid_i = 1'b0;
      end else begin
        cfg_valid_i = 1'b1;
        cfg_data_i  = 16'(n + 1);
        wq.push_back('{addr: EXP_ADDR[n], data: 16'(n + 1)});
        n++;
      end
      tog = !tog;
      @(negedge clk_i);
    end
    cfg_valid_i = 1'b0;
    check("loaded_after_last", {31'd0, loaded_o}, 32'd1);
    check("load_done_busy", {31'd0, busy_o}, 32'd0);
    check("load_done_ready", {31'd0, cfg_ready_o}, 32'd0);
  endtask

  // Handshakes during LOADED and START are offered and must be ignored.
  task automatic do_run(input int unsigned gap, input bit noise, input logic [15:0] exp_cnt);
    run_i = 1'b1;
    layer_valid_i = 1'b1;
    layer_ready_i = 1'b1;
    pending_starts++;
    @(negedge clk_i);
    run_i = 1'b0;
    check("start_pulse", {31'd0, layer_start_o}, 32'd1);
    check("start_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    layer_valid_i = 1'b0;
    layer_ready_i = 1'b0;
    check("start_one_cycle", {31'd0, layer_start_o}, 32'd0);
    if (noise) begin
      load_i = 1'b1;
      run_i = 1'b1;
      cfg_valid_i = 1'b1;
      cfg_data_i = 16'hDEAD;
      @(negedge clk_i);
      load_i = 1'b0;
      run_i = 1'b0;
      cfg_valid_i = 1'b0;
      check("run_noise_busy", {31'd0, busy_o}, 32'd1);
      check("run_noise_ready", {31'd0, cfg_ready_o}, 32'd0);
      check("run_noise_wen", {31'd0, wen_o}, 32'd0);
      check("run_noise_loaded", {31'd0, loaded_o}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      layer_valid_i = 1'b1;
      layer_ready_i = 1'b1;
      if (i == 4) fq.push_back(exp_cnt);
      @(negedge clk_i);
      layer_ready_i = 1'b0;
      if (i == 4) check("frame_done_timing", {31'd0, frame_done_o}, 32'd1);
      else check("no_early_done", {31'd0, frame_done_o}, 32'd0);
      repeat (gap) @(negedge clk_i);
      layer_valid_i = 1'b0;
    end
    check("run_end_busy", {31'd0, busy_o}, 32'd0);
    check("run_end_count", {16'd0, frame_count_o}, {16'd0, exp_cnt});
  endtask

  initial begin
    #1;
    check("reset_wen", {31'd0, wen_o}, 32'd0);
    check("reset_loaded", {31'd0, loaded_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_count", {16'd0, frame_count_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // run_i and cfg_valid_i in IDLE are ignored.
    run_i = 1'b1;
    cfg_valid_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
    cfg_valid_i = 1'b0;
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_ready", {31'd0, cfg_ready_o}, 32'd0);
    check("idle_wen", {31'd0, wen_o}, 32'd0);
    check("idle_start", {31'd0, layer_start_o}, 32'd0);

    do_load(1'b0, 1'b0);
    do_run(1, 1'b0, 16'd1);
    do_run(2, 1'b1, 16'd2);
    do_load(1'b1, 1'b0);
    do_run(0, 1'b0, 16'd3);
    do_load(1'b0, 1'b1);

    // Partial reload interrupted by reset after 7 words.
    @(negedge clk_i);
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    for (int n = 0; n < 7; n++) begin
      cfg_valid_i = 1'b1;
      cfg_data_i = 16'(n + 1);
      wq.push_back('{addr: EXP_ADDR[n], data: 16'(n + 1)});
      @(negedge clk_i);
    end
    #1;
    reset_i = 1'b1;
    cfg_valid_i = 1'b0;
    #1;
    check("async_reset_wen", {31'd0, wen_o}, 32'd0);
    check("async_reset_loaded", {31'd0, loaded_o}, 32'd0);
    check("async_reset_busy", {31'd0, busy_o}, 32'd0);
    check("async_reset_ready", {31'd0, cfg_ready_o}, 32'd0);
    check("async_reset_count", {16'd0, frame_count_o}, 32'd0);
    check("async_reset_addr", {27'd0, mem_addr_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_idle", {31'd0, busy_o}, 32'd0);

    do_load(1'b0, 1'b0);
    do_run(1, 1'b0, 16'd1);

    repeat (3) @(negedge clk_i);
    check("writes_drained", wq.size(), 32'd0);
    check("frames_drained", fq.size(), 32'd0);
    check("starts_drained", pending_starts, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
